// File: rtl/simd_shifter_pipe_pkg.sv
// Shared types, encodings and lane helpers for the pipelined SIMD shifter.
package simd_shifter_pipe_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [2:0] op_t;
    typedef logic [5:0] shift_t;

    localparam mode_t MODE_B = 2'd0;
    localparam mode_t MODE_H = 2'd1;
    localparam mode_t MODE_W = 2'd2;
    localparam mode_t MODE_D = 2'd3;

    localparam op_t OP_SLL = 3'd0;
    localparam op_t OP_SRL = 3'd1;
    localparam op_t OP_SRA = 3'd2;
    localparam op_t OP_ROL = 3'd3;
    localparam op_t OP_ROR = 3'd4;

    // Lane width in bits for a given mode: 8, 16, 32 or 64.
    function automatic int unsigned lane_width(mode_t m);
        return 32'd8 << m;
    endfunction

    // Mask that reduces a raw shift entry modulo the lane width.
    function automatic shift_t amt_mask(mode_t m);
        return shift_t'(lane_width(m) - 32'd1);
    endfunction

    // Encodings above ROR are reserved.
    function automatic logic op_reserved(op_t op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/simd_shifter_pipe_lane.sv
// Combinational shifter for one 64-bit slice; lanes never straddle a slice.
module simd_shifter_pipe_lane
    import simd_shifter_pipe_pkg::*;
(
    input  logic [63:0]  i_slice,
    input  mode_t        i_mode,
    input  op_t          i_op,
    input  shift_t [7:0] i_shift,
    output logic [63:0]  o_slice
);

    // Lane value is held right-aligned and zero-extended in 64 bits.
    function automatic logic [63:0] lane_op(logic [63:0] v, int unsigned lw,
                                            shift_t amt, op_t op);
        logic [63:0]  m;
        logic [63:0]  fill;
        shift_t       a;
        int unsigned  ra;
        m    = (lw >= 32'd64) ? '1 : ((64'd1 << lw) - 64'd1);
        a    = amt & shift_t'(lw - 32'd1);
        ra   = lw - 32'(a);
        fill = (((v >> (lw - 32'd1)) & 64'd1) != 64'd0) ? (m & ~(m >> a)) : '0;
        case (op)
            OP_SLL:  lane_op = (v << a) & m;
            OP_SRL:  lane_op = v >> a;
            OP_SRA:  lane_op = (v >> a) | fill;
            OP_ROL:  lane_op = ((v << a) | (v >> ra)) & m;
            OP_ROR:  lane_op = ((v >> a) | (v << ra)) & m;
            default: lane_op = v;
        endcase
    endfunction

    // Each lane takes the shift entry of its lowest byte.
    always_comb begin
        o_slice = i_slice;
        case (i_mode)
            MODE_B: begin
                for (int unsigned k = 0; k < 8; k++)
                    o_slice[k*8 +: 8] = 8'(lane_op(64'(i_slice[k*8 +: 8]), 32'd8, i_shift[k], i_op));
            end
            MODE_H: begin
                for (int unsigned k = 0; k < 4; k++)
                    o_slice[k*16 +: 16] = 16'(lane_op(64'(i_slice[k*16 +: 16]), 32'd16, i_shift[k*2], i_op));
            end
            MODE_W: begin
                for (int unsigned k = 0; k < 2; k++)
                    o_slice[k*32 +: 32] = 32'(lane_op(64'(i_slice[k*32 +: 32]), 32'd32, i_shift[k*4], i_op));
            end
            default: o_slice = lane_op(i_slice, 32'd64, i_shift[0], i_op);
        endcase
    end

endmodule

// File: rtl/simd_shifter_pipe.sv
// Two-stage pipelined SIMD shift/rotate unit with valid/ready handshakes.
module simd_shifter_pipe
    import simd_shifter_pipe_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  mode_t                in_mode,
    input  op_t                  in_op,
    input  shift_t [W/8-1:0]     in_shift,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    localparam int unsigned NSLICE = W / 64;

    logic                 r_s1_valid;
    logic [W-1:0]         r_s1_data;
    mode_t                r_s1_mode;
    op_t                  r_s1_op;
    shift_t [W/8-1:0]     r_s1_amt;
    logic [TAG_W-1:0]     r_s1_tag;
    logic                 r_s1_err;

    logic                 r_s2_valid;
    logic [W-1:0]         r_s2_data;
    logic [TAG_W-1:0]     r_s2_tag;
    logic                 r_s2_err;

    logic                 w_adv1;
    logic                 w_adv2;
    shift_t [W/8-1:0]     w_amt;
    logic [W-1:0]         w_shifted;

    // Stage advance; out_ready reaches in_ready combinationally.
    always_comb begin
        w_adv2   = !r_s2_valid || out_ready;
        w_adv1   = !r_s1_valid || w_adv2;
        in_ready = w_adv1;
    end

    // Reduce every shift entry modulo the lane width before registering.
    always_comb begin
        w_amt = '0;
        for (int unsigned b = 0; b < W/8; b++)
            w_amt[b] = in_shift[b] & amt_mask(in_mode);
    end

    // S1: capture the request together with its decoded amounts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= MODE_B;
            r_s1_op    <= OP_SLL;
            r_s1_amt   <= '0;
            r_s1_tag   <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= in_mode;
                r_s1_op   <= in_op;
                r_s1_amt  <= w_amt;
                r_s1_tag  <= in_tag;
                r_s1_err  <= op_reserved(in_op);
            end
        end
    end

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        simd_shifter_pipe_lane u_lane (
            .i_slice (r_s1_data[g*64 +: 64]),
            .i_mode  (r_s1_mode),
            .i_op    (r_s1_op),
            .i_shift (r_s1_amt[g*8 +: 8]),
            .o_slice (w_shifted[g*64 +: 64])
        );
    end

    // S2: register the shifted result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= r_s1_err ? r_s1_data : w_shifted;
                r_s2_tag  <= r_s1_tag;
                r_s2_err  <= r_s1_err;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;
    assign out_err   = r_s2_err;

endmodule

// File: tb/tb_simd_shifter_pipe.sv
// Self-checking bench for simd_shifter_pipe: directed table, stall and reset
// sequences, and a random phase checked through a scoreboard.
module tb_simd_shifter_pipe;
    import simd_shifter_pipe_pkg::*;

    localparam int unsigned W     = 64;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NB    = W / 8;

    typedef shift_t [NB-1:0] shv_t;

    typedef struct {
        mode_t        mode;
        op_t          op;
        logic [W-1:0] data;
        shv_t         sh;
        logic [W-1:0] exp;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0]     data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    mode_t            in_mode;
    op_t              in_op;
    shv_t             in_shift;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t sb_e;
    vec_t tbl[9];

    simd_shifter_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_op     (in_op),
        .in_shift  (in_shift),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: every result bit is picked from a source bit of the same lane.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input mode_t m,
                                           input op_t op, input shv_t sh);
        int L;
        int a;
        int src;
        logic [W-1:0] r;
        if (op > 3'd4) return d;
        L = 8 << m;
        r = '0;
        for (int base = 0; base < int'(W); base += L) begin
            a = int'(sh[base/8]) % L;
            for (int i = 0; i < L; i++) begin
                case (op)
                    3'd0:    src = i - a;
                    3'd1:    src = (i + a < L) ? i + a : -1;
                    3'd2:    src = (i + a < L) ? i + a : L - 1;
                    3'd3:    src = (i - a + L) % L;
                    default: src = (i + a) % L;
                endcase
                r[base + i] = (src < 0) ? 1'b0 : d[base + src];
            end
        end
        return r;
    endfunction

    // Scoreboard: predict on accept, compare on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_spurious: got tag 0x%0h, want no output", out_tag);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_data", 64'(out_data), 64'(sb_e.data));
                    check("sb_tag",  64'(out_tag),  64'(sb_e.tag));
                    check("sb_err",  64'(out_err),  64'(sb_e.err));
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{data: model(in_data, in_mode, in_op, in_shift),
                               tag: in_tag, err: (in_op > 3'd4)});
        end
    end

    // Present a request at posedge+1 and return 1 ns after the accepting edge.
    task automatic send(input mode_t m, input op_t op, input logic [W-1:0] d,
                        input shv_t sh, input logic [TAG_W-1:0] tag);
        int waited = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_op    = op;
        in_data  = d;
        in_shift = sh;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0, want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One request through an idle pipe: visible after the edge following acceptance.
    task automatic run_directed(input vec_t v, input logic [TAG_W-1:0] tag);
        out_ready = 1'b1;
        send(v.mode, v.op, v.data, v.sh, tag);
        check("dir_early_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("dir_valid", 64'(out_valid), 64'd1);
        check("dir_data",  64'(out_data),  64'(v.exp));
        check("dir_err",   64'(out_err),   64'(v.err));
        check("dir_tag",   64'(out_tag),   64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_idle",  64'(out_valid), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bd[5];
        mode_t        bm[5];
        op_t          bo[5];
        shv_t         bs[5];
        shv_t         s;
        int           nxt;
        logic         acc;

        // Directed vectors: {mode, op, data, shift entries, expected, err}.
        s = '0; for (int b = 0; b < int'(NB); b++) s[b] = 6'd1;
        tbl[0] = '{MODE_B, OP_SLL, 64'h0102040810204080, s, 64'h0204081020408000, 1'b0};
        s = '0; for (int b = 0; b < int'(NB); b++) s[b] = 6'd7;
        s[6] = 6'd15; s[4] = 6'd15; s[2] = 6'd4; s[0] = 6'd1;
        tbl[1] = '{MODE_H, OP_SRA, 64'h80007FFFF0000001, s, 64'hFFFF0000FF000000, 1'b0};
        s = '0; s[0] = 6'd1;
        tbl[2] = '{MODE_D, OP_ROR, 64'h0000000000000001, s, 64'h8000000000000000, 1'b0};
        s = '0; s[4] = 6'd33; s[0] = 6'd33;
        tbl[3] = '{MODE_W, OP_ROL, 64'h8000000000000001, s, 64'h0000000100000002, 1'b0};
        s = '0; for (int b = 0; b < int'(NB); b++) s[b] = 6'(b * 5 + 3);
        tbl[4] = '{MODE_H, 3'd6, 64'hDEADBEEFCAFEF00D, s, 64'hDEADBEEFCAFEF00D, 1'b1};
        s = '0; for (int b = 0; b < int'(NB); b++) s[b] = 6'd8;
        tbl[5] = '{MODE_B, OP_SRL, 64'h0123456789ABCDEF, s, 64'h0123456789ABCDEF, 1'b0};
        s = '0; s[0] = 6'd63;
        tbl[6] = '{MODE_D, OP_SRA, 64'h8000000000000000, s, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        s = '0; s[0] = 6'd20; s[2] = 6'd20; s[4] = 6'd20; s[6] = 6'd20;
        tbl[7] = '{MODE_H, OP_ROR, 64'h123456789ABCDEF0, s, 64'h41238567C9AB0DEF, 1'b0};
        s = '0;
        tbl[8] = '{MODE_W, 3'd7, 64'h0000FFFF0000FFFF, s, 64'h0000FFFF0000FFFF, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = MODE_B;
        in_op     = OP_SLL;
        in_shift  = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_out_err",   64'(out_err),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_directed(tbl[i], 4'(i));

        // Stall: five requests against out_ready held low for four cycles.
        for (int i = 0; i < 5; i++) begin
            bd[i] = {$urandom(), $urandom()};
            bm[i] = mode_t'($urandom_range(0, 3));
            bo[i] = op_t'($urandom_range(0, 4));
            for (int b = 0; b < int'(NB); b++) bs[i][b] = 6'($urandom());
        end
        out_ready = 1'b0;
        nxt = 0;
        for (int cyc = 0; cyc < 40 && nxt < 5; cyc++) begin
            if (cyc == 4) out_ready = 1'b1;
            in_valid = 1'b1;
            in_data  = bd[nxt];
            in_mode  = bm[nxt];
            in_op    = bo[nxt];
            in_shift = bs[nxt];
            in_tag   = 4'(nxt);
            @(negedge clk);
            if (cyc == 2) begin
                check("bp_accepted_two", 64'(nxt), 64'd2);
                check("bp_in_ready_drop", 64'(in_ready), 64'd0);
            end
            if (cyc == 2 || cyc == 3) begin
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_tag",   64'(out_tag),   64'd0);
                check("bp_hold_err",   64'(out_err),   64'd0);
                check("bp_hold_data",  64'(out_data),  64'(model(bd[0], bm[0], bo[0], bs[0])));
            end
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) nxt++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(nxt), 64'd5);
        drain();

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(MODE_B, OP_SLL, 64'h1111111111111111, '0, 4'hA);
        send(MODE_B, OP_SRL, 64'h2222222222222222, '0, 4'hB);
        check("rstmf_full_ready", 64'(in_ready),  64'd0);
        check("rstmf_full_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmf_async_valid", 64'(out_valid), 64'd0);
        check("rstmf_in_ready",    64'(in_ready),  64'd1);
        check("rstmf_out_data",    64'(out_data),  64'd0);
        check("rstmf_out_tag",     64'(out_tag),   64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("rstmf_ready_after", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rstmf_no_stale", 64'(out_valid), 64'd0);
        end
        run_directed(tbl[3], 4'h5);

        // Random traffic with random backpressure, including reserved ops.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom(), $urandom()};
            in_mode   = mode_t'($urandom_range(0, 3));
            in_op     = op_t'($urandom_range(0, 7));
            for (int b = 0; b < int'(NB); b++) in_shift[b] = 6'($urandom());
            in_tag    = 4'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
